// File: rtl/mult_seq_16_pkg.sv
// Shared constants for the sequential 16x16 shift-and-add multiplier.
package mult_seq_16_pkg;

   localparam int unsigned W    = 16;
   localparam int unsigned ITER = 16;
   localparam int unsigned CW   = 4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mult_seq_16_adder.sv
// 16-bit ripple-carry adder (Adder_16): the only arithmetic element of the multiplier datapath.
module mult_seq_16_adder
   import mult_seq_16_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum_c,
   output logic         carry_c
);

   // Full-adder chain, LSB first; cy is a per-evaluation temporary.
   always_comb begin
      logic cy;
      cy    = 1'b0;
      sum_c = '0;
      for (int i = 0; i < int'(W); i++) begin
         sum_c[i] = a[i] ^ b[i] ^ cy;
         cy       = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      end
      carry_c = cy;
   end

endmodule

// File: rtl/mult_seq_16.sv
// Sequential unsigned 16x16 multiplier: one shared ripple adder, one iteration per cycle, 17-cycle latency.
module mult_seq_16
   import mult_seq_16_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] p
);

   logic [1:0]     state, state_n;
   logic [CW-1:0]  count, count_n;
   logic [W-1:0]   mcand, mcand_n;
   logic [W-1:0]   acc, acc_n;
   logic [W-1:0]   q, q_n;
   logic [2*W-1:0] p_n;
   logic [W-1:0]   addend;
   logic [W-1:0]   sum;
   logic           carry;

   assign addend = mcand & {W{q[0]}};

   mult_seq_16_adder u_adder_16 (
      .a       (acc),
      .b       (addend),
      .sum_c   (sum),
      .carry_c (carry)
   );

   // Next-state and datapath update
   always_comb begin
      state_n = state;
      count_n = count;
      mcand_n = mcand;
      acc_n   = acc;
      q_n     = q;
      p_n     = p;
      case (state)
         IDLE, DONE: begin
            state_n = IDLE;
            if (start) begin
               state_n = RUN;
               mcand_n = a;
               acc_n   = '0;
               q_n     = b;
               count_n = '0;
            end
         end
         RUN: begin
            // Carry becomes the new acc MSB, so it is never lost.
            {acc_n, q_n} = {carry, sum, q[W-1:1]};
            count_n      = count + CW'(1);
            if (count == CW'(ITER - 1)) begin
               state_n = DONE;
               p_n     = {carry, sum, q[W-1:1]};
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         mcand <= '0;
         acc   <= '0;
         q     <= '0;
         p     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         mcand <= mcand_n;
         acc   <= acc_n;
         q     <= q_n;
         p     <= p_n;
         busy  <= (state_n == RUN);
         done  <= (state_n == DONE);
      end
   end

endmodule

// File: doc/mult_seq_16.md
Name: mult_seq_16

Overview:
- Sequential unsigned 16x16 shift-and-add multiplier controller. It produces a 32-bit product.
- Time-shares one 16-bit ripple-carry adder (Adder_16) over 16 iterations instead of instantiating an array multiplier.
- Sits between a simple start/done requester and the adder datapath; owns all sequencing, operand and partial-product registers.

Parameters:
- W, 16, operand width; the product is 2*W bits. Only 16 is supported, because the adder instance is fixed at 16 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when not busy
- a  input  16  multiplicand, captured on an accepted start
- b  input  16  multiplier, captured on an accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when p becomes valid
- p  output  32  product, held stable until the next accepted start

Behaviour:
- Reset (sampled at a clk edge): state=IDLE, busy=0, done=0, p=0, count=0, all internal registers 0. Reset dominates start.
- States:
  - IDLE: busy=0. start=1 moves to RUN and loads mcand<=a, acc<=0, q<=b, count<=0. p keeps its previous value.
  - RUN: busy=1. One iteration per cycle:
    - Adder inputs: acc and (q[0] ? mcand : 16'h0000).
    - Adder produces sum[15:0] and carry.
    - Update {acc,q} <= {carry, sum, q[15:1]}, i.e. the 33-bit value shifted right by 1.
    - count<=count+1.
    - When count==15 at the edge, go to DONE and write p<={new acc, new q}.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE.
    - start=1 in DONE is accepted exactly as in IDLE: load operands, go to RUN. done still pulses this cycle.
- Latency: start accepted at edge k; RUN occupies edges k+1..k+16. done=1 and p valid in the cycle after edge k+16, i.e. 17 cycles after acceptance. Throughput is one product per 17 cycles with back-to-back starts.
- start while busy=1 is ignored: no queuing, and operands are not re-captured.
- a and b may change freely after acceptance; they are not used.
- p updates only on the final RUN edge and never shows partial products.
- Carry out of the adder is never lost; it becomes acc[15] after the shift.
- Full-range result: 0xFFFF*0xFFFF = 0xFFFE0001.
- Reset mid-RUN aborts the operation: no done pulse, and p clears to 0.
- count is 4 bits and wraps 15->0 only on the transition to DONE.
- The adder is the only arithmetic element. The datapath contains no behavioural "+" except the 4-bit counter increment.

Decomposition:
- Shared package: state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2; width constant W=16; iteration count localparam ITER=16.
- One sub-module: the existing 16-bit ripple adder (Adder_16), instantiated once.
- The addend mux (q[0] gating of mcand) is a 16-bit AND and stays inline.
- FSM, counter and shift registers stay in mult_seq_16.

Test Plan:
- Reset, then start with a=3, b=5 -> busy high for 16 cycles; done pulses once 17 cycles after start; p=32'h0000000F held afterwards.
- a=16'hFFFF, b=16'hFFFF -> p=32'hFFFE0001 (exercises adder carry every iteration); a=16'h8000, b=16'h0002 -> p=32'h00010000.
- a=0, b=16'h1234 and a=16'h1234, b=0 -> p=0; timing identical to the non-zero cases.
- Start a=7, b=9; pulse start with a=2, b=2 at cycle 5 of RUN -> ignored; p=32'h0000003F, single done pulse.
- Start a=100, b=200; assert reset at RUN cycle 8 -> next cycle busy=0, done=0, p=0; no done pulse ever appears. A new start a=10, b=10 -> p=100.
- Hold start high on the done cycle with a=16'h0102, b=16'h0304 after a prior 6*7 -> first p=42 with done; immediate re-entry to RUN; second p=32'h0003_0A08 17 cycles later.
